tnn_sample_sequencer: RTL and testbench

Front-end and result-collection block for the sequential ternary classifiers (`seq_tnn` and its per-dataset wrappers). It accepts one sample as a serial stream of `FEAT_BITS`-wide features and packs them into the parallel `features` word the classifier consumes. It holds that word stable while the classifier runs for a fixed number of cycles, then captures `prediction` and returns it over a valid/ready result port. It is the driving end of the classifier's `features`/`prediction` interface. The classifier has no start/done handshake, so this block owns sequencing and latency.

---
 rtl/tnn_sample_sequencer.sv | 113 +++++++++++
 tb/tb_tnn_sample_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnn_sample_sequencer.sv
// Serial feature packer and result collector for the sequential ternary classifier.
// Packs one sample, restarts the classifier, waits a fixed latency, then hands back the class.
module tnn_sample_sequencer #(
    parameter int FEAT_CNT     = 12,
    parameter int FEAT_BITS    = 4,
    parameter int CLASS_CNT    = 6,
    parameter int INFER_CYCLES = 64,
    localparam int CW          = $clog2(CLASS_CNT)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic [FEAT_BITS-1:0]          s_data_i,
    input  logic                          s_last_i,
    output logic [FEAT_CNT*FEAT_BITS-1:0] features_o,
    output logic                          clf_start_o,
    input  logic [CW-1:0]                 prediction_i,
    output logic                          r_valid_o,
    input  logic                          r_ready_i,
    output logic [CW-1:0]                 r_class_o,
    output logic                          frame_err_o,
    output logic [15:0]                   sample_cnt_o
);

    localparam int BW = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
    localparam int WW = (INFER_CYCLES > 1) ? $clog2(INFER_CYCLES) : 1;
    localparam int FW = FEAT_CNT * FEAT_BITS;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t         state_q;
    logic [BW-1:0]  beat_q;
    logic [WW-1:0]  wait_q;
    logic [FW-1:0]  buf_q;
    logic [FW-1:0]  buf_d;
    logic [FW-1:0]  features_q;
    logic [CW-1:0]  r_class_q;
    logic           frame_err_q;
    logic [15:0]    sample_cnt_q;

    // Buffer including the beat currently on the bus, so completion can publish it on the same edge.
    always_comb begin
        buf_d = buf_q;
        buf_d[int'(beat_q)*FEAT_BITS +: FEAT_BITS] = s_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_LOAD;
            beat_q       <= '0;
            wait_q       <= '0;
            buf_q        <= '0;
            features_q   <= '0;
            r_class_q    <= '0;
            frame_err_q  <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    if (s_valid_i) begin
                        buf_q <= buf_d;
                        if (beat_q == BW'(FEAT_CNT - 1)) begin
                            features_q  <= buf_d;
                            beat_q      <= '0;
                            frame_err_q <= ~s_last_i;
                            state_q     <= ST_START;
                        end else if (s_last_i) begin
                            beat_q      <= '0;
                            frame_err_q <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    wait_q  <= WW'(INFER_CYCLES - 1);
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_q == '0) begin
                        r_class_q <= prediction_i;
                        state_q   <= ST_DONE;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (r_ready_i) begin
                        sample_cnt_q <= sample_cnt_q + 16'd1;
                        state_q      <= ST_LOAD;
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    assign s_ready_o    = (state_q == ST_LOAD);
    assign clf_start_o  = (state_q == ST_START);
    assign r_valid_o    = (state_q == ST_DONE);
    assign features_o   = features_q;
    assign r_class_o    = r_class_q;
    assign frame_err_o  = frame_err_q;
    assign sample_cnt_o = sample_cnt_q;

endmodule

// File: tb/tb_tnn_sample_sequencer.sv
// Directed-plus-random bench for tnn_sample_sequencer against a beat-level reference model.
module tb_tnn_sample_sequencer;

    localparam int FC = 12;
    localparam int FB = 4;
    localparam int IC = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [3:0]  s_data_i;
    logic        s_last_i;
    logic [47:0] features_o;
    logic        clf_start_o;
    logic [2:0]  prediction_i;
    logic        r_valid_o;
    logic        r_ready_i;
    logic [2:0]  r_class_o;
    logic        frame_err_o;
    logic [15:0] sample_cnt_o;

    tnn_sample_sequencer #(
        .FEAT_CNT(FC), .FEAT_BITS(FB), .CLASS_CNT(6), .INFER_CYCLES(IC)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
        .features_o(features_o), .clf_start_o(clf_start_o), .prediction_i(prediction_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_class_o(r_class_o),
        .frame_err_o(frame_err_o), .sample_cnt_o(sample_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Stand-in classifier: class is feature 0 modulo the class count.
    assign prediction_i = 3'(features_o[3:0] % 4'd6);

    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  bd[FC];
    bit          bl[FC];
    logic [3:0]  mbuf[FC];
    int          mk;
    logic [47:0] exp_feat;
    int          exp_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_s_ready"},   64'(s_ready_o),    64'(1));
        chk({tag, "_features"},  64'(features_o),   64'(0));
        chk({tag, "_clf_start"}, 64'(clf_start_o),  64'(0));
        chk({tag, "_r_valid"},   64'(r_valid_o),    64'(0));
        chk({tag, "_r_class"},   64'(r_class_o),    64'(0));
        chk({tag, "_frame_err"}, 64'(frame_err_o),  64'(0));
        chk({tag, "_cnt"},       64'(sample_cnt_o), 64'(0));
    endtask

    task automatic model_reset();
        mk       = 0;
        exp_feat = '0;
        exp_cnt  = 0;
    endtask

    task automatic fill_random(input int last_at);
        for (int k = 0; k < FC; k++) begin
            bd[k] = 4'($urandom);
            bl[k] = (k == last_at);
        end
    endtask

    // Offer beats 0..n-1; the model tracks the sample position independently of the DUT.
    task automatic feed(input int n, input bit stall);
        bit rdy;
        bit acc;
        bit efe;
        bit est;
        logic [47:0] packed_w;
        for (int k = 0; k < n; k++) begin
            if (stall)
                for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
                    s_valid_i = 1'b0;
                    step();
                end
            s_valid_i = 1'b1;
            s_data_i  = bd[k];
            s_last_i  = bl[k];
            acc = 1'b0;
            for (int t = 0; t < 50 && !acc; t++) begin
                rdy = s_ready_o;
                step();
                acc = rdy;
            end
            s_valid_i = 1'b0;
            s_last_i  = 1'b0;
            if (!acc) begin
                chk("beat_accept", 64'(0), 64'(1));
                continue;
            end
            mbuf[mk] = bd[k];
            if (mk == FC - 1) begin
                packed_w = '0;
                for (int j = 0; j < FC; j++) packed_w = packed_w | (48'(mbuf[j]) << (FB * j));
                exp_feat = packed_w;
                efe = !bl[k];
                est = 1'b1;
                mk  = 0;
            end else if (bl[k]) begin
                efe = 1'b1;
                est = 1'b0;
                mk  = 0;
            end else begin
                efe = 1'b0;
                est = 1'b0;
                mk++;
            end
            chk("frame_err", 64'(frame_err_o), 64'(efe));
            chk("clf_start", 64'(clf_start_o), 64'(est));
            chk("features",  64'(features_o),  64'(exp_feat));
        end
    endtask

    // Called just after the edge that accepted the final beat.
    task automatic wait_result(input int hold, input bit early_rdy);
        int n;
        logic [2:0] ecls;
        ecls      = 3'(exp_feat[3:0] % 4'd6);
        r_ready_i = early_rdy;
        n = 0;
        while (!r_valid_o && n < 100) begin
            chk("s_ready_busy", 64'(s_ready_o),  64'(0));
            chk("feat_stable",  64'(features_o), 64'(exp_feat));
            step();
            n++;
            chk("frame_err_pulse", 64'(frame_err_o), 64'(0));
            if (!r_valid_o) chk("clf_start_once", 64'(clf_start_o), 64'(0));
        end
        chk("latency", 64'(n), 64'(IC + 1));
        chk("r_class", 64'(r_class_o), 64'(ecls));
        if (!early_rdy)
            for (int h = 0; h < hold; h++) begin
                s_valid_i = 1'b1;
                s_data_i  = 4'($urandom);
                s_last_i  = 1'b1;
                step();
                chk("bp_r_valid",   64'(r_valid_o),   64'(1));
                chk("bp_r_class",   64'(r_class_o),   64'(ecls));
                chk("bp_s_ready",   64'(s_ready_o),   64'(0));
                chk("bp_frame_err", 64'(frame_err_o), 64'(0));
            end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        r_ready_i = 1'b1;
        step();
        r_ready_i = 1'b0;
        exp_cnt++;
        chk("done_r_valid", 64'(r_valid_o),    64'(0));
        chk("done_s_ready", 64'(s_ready_o),    64'(1));
        chk("sample_cnt",   64'(sample_cnt_o), 64'(exp_cnt));
    endtask

    initial begin
        rst_ni    = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        s_last_i  = 1'b0;
        r_ready_i = 1'b0;
        model_reset();
        #1;
        chk_reset("por");
        repeat (2) step();
        rst_ni = 1'b1;
        step();

        // Nominal sample 0x1..0xC with r_ready held high
        for (int k = 0; k < FC; k++) begin
            bd[k] = 4'(k + 1);
            bl[k] = (k == FC - 1);
        end
        feed(FC, 1'b0);
        chk("nom_feat", 64'(features_o), 64'h0000_CBA9_8765_4321);
        wait_result(0, 1'b1);

        // Backpressure in DONE while beats are offered
        fill_random(FC - 1);
        feed(FC, 1'b0);
        wait_result(10, 1'b0);

        // Early last on beat 5, then a clean sample
        fill_random(5);
        feed(6, 1'b0);
        repeat (3) begin
            step();
            chk("early_no_start", 64'(clf_start_o), 64'(0));
            chk("early_feat",     64'(features_o),  64'(exp_feat));
            chk("early_fe_pulse", 64'(frame_err_o), 64'(0));
        end
        fill_random(FC - 1);
        feed(FC, 1'b0);
        wait_result(2, 1'b0);

        // Missing last
        fill_random(-1);
        feed(FC, 1'b0);
        wait_result(0, 1'b0);

        // Stalled input stream
        repeat (3) begin
            fill_random(FC - 1);
            feed(FC, 1'b1);
            wait_result($urandom_range(0, 3), 1'b0);
        end

        // Reset in WAIT
        fill_random(FC - 1);
        feed(FC, 1'b0);
        step();
        step();
        rst_ni = 1'b0;
        #1;
        chk_reset("rst_wait");
        model_reset();
        step();
        step();
        rst_ni = 1'b1;
        step();
        chk("rst_wait_no_start", 64'(clf_start_o), 64'(0));
        chk("rst_wait_s_ready",  64'(s_ready_o),   64'(1));

        // Reset after 7 beats of a sample
        fill_random(-1);
        feed(7, 1'b0);
        rst_ni = 1'b0;
        #1;
        chk_reset("rst_beat");
        model_reset();
        step();
        rst_ni = 1'b1;
        step();
        chk("rst_beat_no_start", 64'(clf_start_o), 64'(0));

        fill_random(FC - 1);
        feed(FC, 1'b0);
        wait_result(1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
